// File: rtl/upf_pwr_seq_ctrl.sv
// Power sequencer for one switchable retention domain: orders clock, isolation, retention and rail controls.
// All outputs registered; one timed step lasts STEP_DLY cycles; no backpressure, ack waits bounded by ACK_TO.
module upf_pwr_seq_ctrl #(
  parameter int unsigned STEP_DLY = 2,
  parameter int unsigned ACK_TO   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sleep_req,
  input  logic wake_req,
  input  logic ret_en,
  input  logic pwr_ack,
  output logic clk_en,
  output logic iso,
  output logic ret,
  output logic pwr,
  output logic busy,
  output logic dom_off,
  output logic err
);

  typedef enum logic [3:0] {
    ST_ON,
    ST_CLK_OFF,
    ST_ISO_ON,
    ST_SAVE,
    ST_PWR_DN,
    ST_OFF,
    ST_PWR_UP,
    ST_RESTORE,
    ST_ISO_OFF
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(STEP_DLY - 1);
  localparam logic [9:0] ACK_LAST  = 10'(ACK_TO - 1);
  localparam logic [9:0] ACK_SAT   = 10'h3ff;

  state_t     state_q, state_d;
  logic       ret_flag_q, ret_flag_d;
  logic [7:0] step_cnt_q;
  logic [9:0] ack_cnt_q;

  logic clk_en_d, iso_d, ret_d, pwr_d, busy_d, dom_off_d, err_d;
  logic step_done, ack_expired, timed, ack_wait;

  assign step_done   = (step_cnt_q == STEP_LAST);
  assign ack_expired = (ack_cnt_q == ACK_LAST);
  assign timed       = (state_q == ST_CLK_OFF) || (state_q == ST_ISO_ON) ||
                       (state_q == ST_SAVE)    || (state_q == ST_RESTORE) ||
                       (state_q == ST_ISO_OFF);
  assign ack_wait    = (state_q == ST_PWR_DN) || (state_q == ST_PWR_UP);

  always_comb begin
    state_d    = state_q;
    ret_flag_d = ret_flag_q;
    clk_en_d   = clk_en;
    iso_d      = iso;
    ret_d      = ret;
    pwr_d      = pwr;
    busy_d     = busy;
    dom_off_d  = dom_off;
    err_d      = err;

    case (state_q)
      ST_ON: begin
        if (sleep_req) begin
          state_d    = ST_CLK_OFF;
          ret_flag_d = ret_en;
          clk_en_d   = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_CLK_OFF: begin
        if (step_done) begin
          state_d = ST_ISO_ON;
          iso_d   = 1'b1;
        end
      end
      ST_ISO_ON: begin
        if (step_done) begin
          if (ret_flag_q) begin
            state_d = ST_SAVE;
            ret_d   = 1'b1;
          end else begin
            state_d = ST_PWR_DN;
            pwr_d   = 1'b0;
          end
        end
      end
      ST_SAVE: begin
        if (step_done) begin
          state_d = ST_PWR_DN;
          pwr_d   = 1'b0;
        end
      end
      ST_PWR_DN: begin
        // A stuck rail still lands in OFF so the domain is never left half-sequenced.
        if (!pwr_ack || ack_expired) begin
          state_d   = ST_OFF;
          busy_d    = 1'b0;
          dom_off_d = 1'b1;
          if (pwr_ack) err_d = 1'b1;
        end
      end
      ST_OFF: begin
        if (wake_req) begin
          state_d   = ST_PWR_UP;
          pwr_d     = 1'b1;
          busy_d    = 1'b1;
          dom_off_d = 1'b0;
        end
      end
      ST_PWR_UP: begin
        if (pwr_ack || ack_expired) begin
          if (!pwr_ack) err_d = 1'b1;
          if (ret_flag_q) begin
            state_d = ST_RESTORE;
            ret_d   = 1'b0;
          end else begin
            state_d = ST_ISO_OFF;
            iso_d   = 1'b0;
          end
        end
      end
      ST_RESTORE: begin
        if (step_done) begin
          state_d = ST_ISO_OFF;
          iso_d   = 1'b0;
        end
      end
      ST_ISO_OFF: begin
        if (step_done) begin
          state_d    = ST_ON;
          clk_en_d   = 1'b1;
          busy_d     = 1'b0;
          ret_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_ON;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_ON;
      ret_flag_q <= 1'b0;
      step_cnt_q <= '0;
      ack_cnt_q  <= '0;
      clk_en     <= 1'b1;
      iso        <= 1'b0;
      ret        <= 1'b0;
      pwr        <= 1'b1;
      busy       <= 1'b0;
      dom_off    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_flag_q <= ret_flag_d;
      clk_en     <= clk_en_d;
      iso        <= iso_d;
      ret        <= ret_d;
      pwr        <= pwr_d;
      busy       <= busy_d;
      dom_off    <= dom_off_d;
      err        <= err_d;

      if (state_d != state_q) begin
        step_cnt_q <= '0;
        ack_cnt_q  <= '0;
      end else begin
        if (timed) step_cnt_q <= step_cnt_q + 8'd1;
        if (ack_wait && (ack_cnt_q != ACK_SAT)) ack_cnt_q <= ack_cnt_q + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_upf_pwr_seq_ctrl.sv
// Bench for upf_pwr_seq_ctrl: vector table for full retained/non-retained cycles, hand sequences for corners.
module tb_upf_pwr_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sleep_req, wake_req, ret_en;
  logic pwr_ack, pwr_ack1, ack_stuck;
  logic clk_en, iso, ret, pwr, busy, dom_off, err;
  logic clk_en1, iso1, ret1, pwr1, busy1, dom_off1, err1;
  logic [6:0] o0, o1;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  inv_on  = 1'b0;
  logic pr0, pr1;

  upf_pwr_seq_ctrl #(.STEP_DLY(2), .ACK_TO(4)) dut (
    .clk(clk), .reset(reset), .sleep_req(sleep_req), .wake_req(wake_req),
    .ret_en(ret_en), .pwr_ack(pwr_ack), .clk_en(clk_en), .iso(iso), .ret(ret),
    .pwr(pwr), .busy(busy), .dom_off(dom_off), .err(err)
  );

  upf_pwr_seq_ctrl #(.STEP_DLY(1), .ACK_TO(16)) dut1 (
    .clk(clk), .reset(reset), .sleep_req(sleep_req), .wake_req(wake_req),
    .ret_en(ret_en), .pwr_ack(pwr_ack1), .clk_en(clk_en1), .iso(iso1), .ret(ret1),
    .pwr(pwr1), .busy(busy1), .dom_off(dom_off1), .err(err1)
  );

  // Rail model: status follows the switch enable one cycle later unless forced stuck-on.
  always @(posedge clk) begin
    pwr_ack  <= ack_stuck | pwr;
    pwr_ack1 <= pwr1;
  end

  assign o0 = {clk_en, iso, ret, pwr, busy, dom_off, err};
  assign o1 = {clk_en1, iso1, ret1, pwr1, busy1, dom_off1, err1};

  typedef struct {
    logic       rst_n;
    logic       sleep;
    logic       wake;
    logic       reten;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {clk_en,iso,ret,pwr,busy,dom_off,err}=%b required %b", nm, act, exp);
    end
  endtask

  task automatic inv(input string tag, input logic [6:0] o, input logic prev_ret);
    logic ok;
    ok = 1'b1;
    if (!o[3] && !(o[5] && !o[6])) ok = 1'b0;
    if (prev_ret && !o[4] && !o[3]) ok = 1'b0;
    if (!prev_ret && o[4] && !(o[3] && o[5])) ok = 1'b0;
    if (!o[2] && !((o[1] && !o[6] && o[5] && !o[3]) ||
                   (!o[1] && o[6] && !o[5] && o[3] && !o[4]))) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL inv_%s: outputs %b prev_ret %b break a sequencing invariant", tag, o, prev_ret);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (inv_on) begin
      inv("dut", o0, pr0);
      inv("dut1", o1, pr1);
    end
    pr0 = o0[4];
    pr1 = o1[4];
  endtask

  task automatic step_chk(input string nm, input bit which, input logic [6:0] exp);
    tick();
    chk(nm, which ? o1 : o0, exp);
  endtask

  initial begin
    reset = 1'b0; sleep_req = 1'b0; wake_req = 1'b0; ret_en = 1'b0; ack_stuck = 1'b0;
    pr0 = 1'b0; pr1 = 1'b0;

    // Retained down/up, then non-retained down/up (STEP_DLY=2, ack one cycle behind pwr).
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b1001000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 7'b0001100};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0001100};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0101100};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0101100};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0111100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0111100};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0110100};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0110100};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0110010};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'b0110010};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0111100};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0111100};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0101100};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0101100};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0001100};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0001100};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b1001000};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0001100};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0001100};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0101100};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0101100};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0100100};
    tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0100100};
    tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0100010};
    tbl[26] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0101100};
    tbl[27] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0101100};
    tbl[28] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0001100};
    tbl[29] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0001100};
    tbl[30] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000};
    tbl[31] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000};

    for (int i = 0; i < 32; i++) begin
      reset     = tbl[i].rst_n;
      sleep_req = tbl[i].sleep;
      wake_req  = tbl[i].wake;
      ret_en    = tbl[i].reten;
      tick();
      chk($sformatf("vec%0d", i), o0, tbl[i].exp);
      inv_on = 1'b1;
    end

    // PWR_ACK stuck high: timeout after ACK_TO=4 cycles in PWR_DN, ERR sticky until reset.
    ack_stuck = 1'b1;
    sleep_req = 1'b1; ret_en = 1'b0;
    step_chk("to_clk_off", 1'b0, 7'b0001100);
    sleep_req = 1'b0;
    tick(); tick(); tick();
    step_chk("to_pwr_dn", 1'b0, 7'b0100100);
    tick(); tick();
    step_chk("to_pre_expiry", 1'b0, 7'b0100100);
    step_chk("to_off_err", 1'b0, 7'b0100011);
    wake_req = 1'b1;
    step_chk("to_pwr_up", 1'b0, 7'b0101101);
    wake_req = 1'b0;
    step_chk("to_iso_off", 1'b0, 7'b0001101);
    tick();
    step_chk("to_on_err_sticky", 1'b0, 7'b1001001);
    reset = 1'b0;
    step_chk("to_err_clear", 1'b0, 7'b1001000);
    reset = 1'b1; ack_stuck = 1'b0;
    tick();

    // Reset held one edge while in SAVE aborts straight to ON values.
    sleep_req = 1'b1; wake_req = 1'b1; ret_en = 1'b1;
    step_chk("rs_clk_off", 1'b0, 7'b0001100);
    sleep_req = 1'b0;
    tick();
    wake_req = 1'b0;
    tick();
    wake_req = 1'b1;
    tick();
    step_chk("rs_save", 1'b0, 7'b0111100);
    wake_req = 1'b0;
    reset = 1'b0;
    step_chk("rs_abort", 1'b0, 7'b1001000);
    reset = 1'b1;
    step_chk("rs_hold_on", 1'b0, 7'b1001000);

    // STEP_DLY=1 instance: single-cycle steps; WAKE held through power-down is acted on once OFF is reached.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    sleep_req = 1'b1; wake_req = 1'b1; ret_en = 1'b1;
    step_chk("s1_clk_off", 1'b1, 7'b0001100);
    sleep_req = 1'b0;
    step_chk("s1_iso_on", 1'b1, 7'b0101100);
    step_chk("s1_save", 1'b1, 7'b0111100);
    step_chk("s1_pwr_dn", 1'b1, 7'b0110100);
    step_chk("s1_pwr_dn_wait", 1'b1, 7'b0110100);
    step_chk("s1_off", 1'b1, 7'b0110010);
    step_chk("s1_pwr_up", 1'b1, 7'b0111100);
    wake_req = 1'b0;
    step_chk("s1_pwr_up_wait", 1'b1, 7'b0111100);
    step_chk("s1_restore", 1'b1, 7'b0101100);
    step_chk("s1_iso_off", 1'b1, 7'b0001100);
    step_chk("s1_on", 1'b1, 7'b1001000);
    step_chk("s1_on_hold", 1'b1, 7'b1001000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/upf_pwr_seq_ctrl.md
Name: upf_pwr_seq_ctrl

Overview:
- Power-sequencing controller for one switchable retention domain.
- Drives the RET, PWR, isolation and clock-enable controls that the domain's retention registers and isolation cells consume.
- Orders power-down as clock-off, isolate, save (RET rise with PWR high), power-off.
- Orders power-up as power-on (RET held high), restore (RET fall with PWR high), de-isolate, clock-on. RET is therefore never released while PWR is low.

Parameters:
- STEP_DLY, 2: cycles each timed step (CLK_OFF, ISO_ON, SAVE, RESTORE, ISO_OFF) is held; legal range 1..255.
- ACK_TO, 16: maximum cycles to wait for PWR_ACK in PWR_DN or PWR_UP before flagging a timeout; legal range 1..1023.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset (0 = reset).
- SLEEP_REQ  in  1  level request to power the domain down; sampled only in ON.
- WAKE_REQ  in  1  level request to power the domain up; sampled only in OFF.
- RET_EN  in  1  selects retention for this power-down; sampled with SLEEP_REQ.
- PWR_ACK  in  1  power-switch status from the domain (1 = rail up, 0 = rail down).
- CLK_EN  out  1  domain clock enable.
- ISO  out  1  isolation enable (1 = isolated).
- RET  out  1  retention control to the domain's retention registers.
- PWR  out  1  power-switch enable (1 = on).
- BUSY  out  1  high while a sequence is in progress.
- DOM_OFF  out  1  high while in state OFF.
- ERR  out  1  sticky PWR_ACK timeout flag; cleared only by RESET.

Behaviour:
- All outputs are registered. Each output changes on the same edge as the state transition that enters the state named for it.
- Reset values (RESET=0 at a rising edge): state ON, CLK_EN=1, ISO=0, RET=0, PWR=1, BUSY=0, DOM_OFF=0, ERR=0, retained flag=0, counters=0.
- Reset mid-sequence aborts immediately to these values, with no ordered unwind.
- ON:
  - SLEEP_REQ=1 at edge k: latch retained flag from RET_EN, go to CLK_OFF, CLK_EN=0, BUSY=1.
  - WAKE_REQ is ignored in ON.
  - If SLEEP_REQ and WAKE_REQ are both high, SLEEP_REQ wins.
- CLK_OFF: hold STEP_DLY cycles, then go to ISO_ON with ISO=1.
- ISO_ON: hold STEP_DLY cycles, then:
  - retained flag=1: go to SAVE with RET=1;
  - retained flag=0: go directly to PWR_DN with PWR=0.
- SAVE: hold STEP_DLY cycles, then go to PWR_DN with PWR=0.
- PWR_DN:
  - PWR_ACK=0 sampled: go to OFF next edge, BUSY=0, DOM_OFF=1.
  - ACK_TO cycles in PWR_DN without PWR_ACK=0: set ERR=1 and go to OFF anyway.
- OFF:
  - WAKE_REQ=1 at edge m: go to PWR_UP, PWR=1, BUSY=1, DOM_OFF=0.
  - SLEEP_REQ is ignored in OFF.
  - RET stays at its saved value throughout OFF.
- PWR_UP:
  - PWR_ACK=1 sampled, or ACK_TO elapsed (then ERR=1), next edge:
    - retained flag=1: go to RESTORE with RET=0;
    - retained flag=0: go to ISO_OFF with ISO=0.
- RESTORE: hold STEP_DLY cycles, then go to ISO_OFF with ISO=0.
- ISO_OFF: hold STEP_DLY cycles, then go to ON with CLK_EN=1, BUSY=0; retained flag cleared.
- Step counter: loads 0 on state entry. A timed state exits at the edge where counter = STEP_DLY-1. It is independent of request levels.
- ACK timeout counter: counts cycles spent in PWR_DN/PWR_UP; saturating, 10 bits wide.
- Requests arriving mid-sequence are ignored, not queued. A level still asserted on reaching ON/OFF is acted on at the next edge.
- Invariants the bench asserts every cycle:
  - PWR=0 implies ISO=1 and CLK_EN=0.
  - A RET fall occurs only while PWR=1.
  - A RET rise occurs only while PWR=1 and ISO=1.
  - BUSY=0 implies state ∈ {ON, OFF}.

Test Plan:
- Retained power-down, STEP_DLY=2, PWR_ACK follows PWR after 1 cycle; SLEEP_REQ=1, RET_EN=1 at edge k -> CLK_EN=0 @k, ISO=1 @k+2, RET=1 @k+4, PWR=0 @k+6, DOM_OFF=1 and BUSY=0 @k+8, ERR=0.
- Retained power-up from that state, ack after 1 cycle; WAKE_REQ at edge m -> PWR=1 @m, RET=0 @m+2, ISO=0 @m+4, CLK_EN=1 and BUSY=0 @m+6; RET never falls while PWR=0.
- Non-retained cycle, RET_EN=0 -> RET stays 0 throughout; power-down goes from ISO_ON directly to PWR_DN (PWR=0 @k+4); power-up has no RESTORE step (ISO=0 @m+2, CLK_EN=1 @m+4).
- PWR_ACK stuck at 1, ACK_TO=4 -> in PWR_DN, ERR=1 after 4 cycles, state OFF; ERR stays 1 through a following WAKE_REQ cycle until RESET=0.
- SLEEP_REQ and WAKE_REQ both high in ON -> power-down starts. Toggling WAKE_REQ during CLK_OFF..SAVE has no effect. RESET=0 held one edge while in SAVE -> next cycle CLK_EN=1, ISO=0, RET=0, PWR=1, BUSY=0.
- STEP_DLY=1 corner -> each timed step lasts exactly 1 cycle; full retained down/up sequence completes with all invariants holding.
